// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver, its transmitter
// counterpart and their benches.
//   UART_DATA_BITS  : payload bits per frame (8N1)
//   UART_IDLE_LEVEL : level of an idle serial line
//   uart_state_t    : frame FSM state encoding
package uart_pkg;

   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: byte-side outputs of the UART receiver.
//   data_out      : last correctly framed byte
//   data_valid    : one-cycle pulse, data_out updated this cycle
//   framing_error : one-cycle pulse, stop bit sampled low
//   busy          : frame in progress
//   state         : FSM state, for debug and checkers
// Handshake: data_valid is a pure strobe with no ready; the consumer must
// take data_out in the cycle data_valid is high or lose it to the next frame.
// master = receiver (drives), slave = byte consumer (observes).
interface uart_rx_if;
   import uart_pkg::*;

   logic [UART_DATA_BITS-1:0] data_out;
   logic                      data_valid;
   logic                      framing_error;
   logic                      busy;
   uart_state_t               state;

   modport master (output data_out, output data_valid, output framing_error,
                   output busy, output state);
   modport slave  (input data_out, input data_valid, input framing_error,
                   input busy, input state);
endinterface

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for asynchronous pad inputs.
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : asynchronous input
//   q          : synchronized output, two cycles behind d
// Both flops reset to RESET_VAL so an idle-high line reads idle from reset.
module uart_sync #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling.
//   CLKS_PER_BIT : clock cycles per bit, 2..255
//   clk, rst_n   : clock, asynchronous active-low reset
//   rx_in        : raw serial line, idle high, asynchronous to clk
//   rx           : byte-side outputs (uart_rx_if master)
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 2
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     rx_in,
   uart_rx_if.master rx
);

   // Offset of the mid-bit sample point into the start bit.
   localparam logic [7:0] HALF = 8'((CLKS_PER_BIT - 1) / 2);
   localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

   logic                      rx_s;
   uart_state_t               state_q;
   logic [7:0]                cnt;
   logic [2:0]                idx;
   logic [UART_DATA_BITS-1:0] sh;
   logic [UART_DATA_BITS-1:0] data_q;
   logic                      valid_q;
   logic                      ferr_q;
   logic                      busy_q;

   uart_sync #(.WIDTH(1), .RESET_VAL(UART_IDLE_LEVEL)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx_in),
      .q     (rx_s)
   );

   // cnt only ever counts up from 0, so "!= limit" is the same test as
   // "< limit" and stays meaningful when HALF is 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         sh      <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               busy_q <= 1'b0;
               if (!rx_s) begin
                  state_q <= START;
                  cnt     <= '0;
                  busy_q  <= 1'b1;
               end
            end
            START: begin
               if (cnt != HALF) begin
                  cnt <= cnt + 8'd1;
               end else if (!rx_s) begin
                  state_q <= DATA;
                  cnt     <= '0;
                  idx     <= '0;
               end else begin
                  // Line went back high before mid start bit: a glitch.
                  state_q <= IDLE;
                  cnt     <= '0;
                  busy_q  <= 1'b0;
               end
            end
            DATA: begin
               if (cnt != LAST) begin
                  cnt <= cnt + 8'd1;
               end else begin
                  sh  <= {rx_s, sh[UART_DATA_BITS-1:1]};
                  cnt <= '0;
                  if (idx == 3'd7) state_q <= STOP;
                  else             idx     <= idx + 3'd1;
               end
            end
            STOP: begin
               if (cnt != LAST) begin
                  cnt <= cnt + 8'd1;
               end else begin
                  cnt <= '0;
                  if (rx_s) begin
                     data_q  <= sh;
                     valid_q <= 1'b1;
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     ferr_q  <= 1'b1;
                     state_q <= WAIT_HIGH;
                  end
               end
            end
            WAIT_HIGH: begin
               // A held-low line must not be re-read as fresh start bits.
               if (rx_s) begin
                  state_q <= IDLE;
                  cnt     <= '0;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt     <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rx.data_out      = data_q;
   assign rx.data_valid    = valid_q;
   assign rx.framing_error = ferr_q;
   assign rx.busy          = busy_q;
   assign rx.state         = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: bench for uart_rx. Two receivers (16 and 2 clocks per bit)
// share clock and reset; one is exercised at a time while the other idles.
// A frame-level model predicts every output each cycle; a scoreboard
// queue tracks the bytes that must be delivered.
module tb_uart_rx;
   import uart_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic rx16  = 1'b1;
   logic rx2   = 1'b1;

   always #5 clk = ~clk;

   uart_rx_if if16 ();
   uart_rx_if if2 ();

   uart_rx #(.CLKS_PER_BIT(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .rx_in(rx16), .rx(if16.master));
   uart_rx #(.CLKS_PER_BIT(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .rx_in(rx2), .rx(if2.master));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   // model outputs
   logic [7:0] exp_data [2];
   bit         exp_dv;
   bit         exp_fe;
   bit         exp_busy;
   int         ms  = 0;     // line the model is following
   int         act = 0;     // line the stimulus is using
   bit         seen;        // model: line level the receiver decides on
   bit         h0 [2];
   bit         h1 [2];

   logic [7:0] exp_q [$];
   int         dv_cnt [2];
   int         fe_cnt [2];
   int         last_dv_cyc16 = 0;

   task automatic chk(input string name, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, got, exp);
      end
   endtask

   function automatic int pack(input logic [7:0] d, input logic v, input logic f,
                               input logic b);
      return int'({21'b0, d, v, f, b});
   endfunction

   // ---------------- model ----------------
   // One clock edge. The receiver acts on the line as captured two edges
   // earlier (two-flop synchronizer).
   task automatic step(output bit ab);
      @(posedge clk);
      if (!rst_n) begin
         ab = 1'b1;
         for (int i = 0; i < 2; i++) begin
            h0[i] = 1'b1; h1[i] = 1'b1; exp_data[i] = 8'h00;
         end
         exp_dv = 1'b0; exp_fe = 1'b0; exp_busy = 1'b0;
      end else begin
         ab     = 1'b0;
         seen   = h1[ms];
         h1[0]  = h0[0]; h0[0] = rx16;
         h1[1]  = h0[1]; h0[1] = rx2;
         exp_dv = 1'b0;
         exp_fe = 1'b0;
      end
   endtask

   // Start sample H edges after detection, data bit k at H+(k+1)*C, stop at
   // H+9*C; each decision lands on the edge following its sample cycle.
   task automatic model_frame(input int c, output bit ab);
      int         h;
      logic [7:0] b;
      h = (c - 1) / 2;
      b = 8'h00;
      repeat (h + 1) begin step(ab); if (ab) return; end
      if (seen) begin exp_busy = 1'b0; return; end
      for (int k = 0; k < 8; k++) begin
         repeat (c) begin step(ab); if (ab) return; end
         b[k] = seen;
      end
      repeat (c) begin step(ab); if (ab) return; end
      if (seen) begin
         exp_data[ms] = b; exp_dv = 1'b1; exp_busy = 1'b0;
      end else begin
         exp_fe = 1'b1;
         do begin step(ab); if (ab) return; end while (!seen);
         exp_busy = 1'b0;
      end
   endtask

   // ---------------- drivers ----------------
   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic drive(input int s, input bit v);
      if (s == 0) rx16 = v; else rx2 = v;
   endtask

   task automatic send(input int s, input logic [7:0] b, input bit stop_bit);
      int c;
      c = (s == 0) ? 16 : 2;
      if (stop_bit) exp_q.push_back(b);
      drive(s, 1'b0); wait_cyc(c);
      for (int k = 0; k < 8; k++) begin drive(s, b[k]); wait_cyc(c); end
      drive(s, stop_bit); wait_cyc(c);
   endtask

   task automatic wait_busy_low(input int s, input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound && !ok; i++) begin
         @(negedge clk);
         if (((s == 0) ? if16.busy : if2.busy) == 1'b0) ok = 1'b1;
      end
      @(posedge clk); #2;
   endtask

   // ---------------- main ----------------
   initial begin
      bit         ok;
      bit         ab;
      int         e1, d0, f0, c, kind, len;
      logic [7:0] b;
      exp_data[0] = 8'h00; exp_data[1] = 8'h00;
      h0[0] = 1'b1; h0[1] = 1'b1; h1[0] = 1'b1; h1[1] = 1'b1;
      dv_cnt[0] = 0; dv_cnt[1] = 0; fe_cnt[0] = 0; fe_cnt[1] = 0;

      fork
         // model process
         forever begin
            ms = act;
            step(ab);
            if (!ab && !seen) begin
               exp_busy = 1'b1;
               model_frame((ms == 0) ? 16 : 2, ab);
            end
         end
         // compare process and scoreboard
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               chk("reset_dut16", pack(if16.data_out, if16.data_valid, if16.framing_error, if16.busy), 0);
               chk("reset_dut2", pack(if2.data_out, if2.data_valid, if2.framing_error, if2.busy), 0);
            end else begin
               chk("cycle_dut16", pack(if16.data_out, if16.data_valid, if16.framing_error, if16.busy),
                   (ms == 0) ? pack(exp_data[0], exp_dv, exp_fe, exp_busy) : pack(exp_data[0], 0, 0, 0));
               chk("cycle_dut2", pack(if2.data_out, if2.data_valid, if2.framing_error, if2.busy),
                   (ms == 1) ? pack(exp_data[1], exp_dv, exp_fe, exp_busy) : pack(exp_data[1], 0, 0, 0));
            end
            if (if16.framing_error) fe_cnt[0]++;
            if (if2.framing_error)  fe_cnt[1]++;
            if (if16.data_valid) begin
               dv_cnt[0]++; last_dv_cyc16 = cyc;
               if (exp_q.size() == 0) chk("sb_unexpected_dut16", int'(if16.data_out), -1);
               else chk("sb_dut16", int'(if16.data_out), int'(exp_q.pop_front()));
            end
            if (if2.data_valid) begin
               dv_cnt[1]++;
               if (exp_q.size() == 0) chk("sb_unexpected_dut2", int'(if2.data_out), -1);
               else chk("sb_dut2", int'(if2.data_out), int'(exp_q.pop_front()));
            end
         end
         begin
            #400000;
            $display("FAIL watchdog: run did not complete");
            $fatal(1, "watchdog");
         end
      join_none

      // reset held with toggling lines
      wait_cyc(1);
      for (int i = 0; i < 12; i++) begin
         rx16 = 1'($urandom_range(0, 1)); rx2 = 1'($urandom_range(0, 1));
         wait_cyc(1);
      end
      chk("reset_hold_dut16", pack(if16.data_out, if16.data_valid, if16.framing_error, if16.busy), 0);
      chk("reset_hold_dut2", pack(if2.data_out, if2.data_valid, if2.framing_error, if2.busy), 0);
      rx16 = 1'b1; rx2 = 1'b1;
      wait_cyc(2);
      rst_n = 1'b1;
      wait_cyc(4);
      chk("reset_no_pulses", dv_cnt[0] + dv_cnt[1] + fe_cnt[0] + fe_cnt[1], 0);

      // glitch on 16x line, then 0x5A
      act = 0;
      drive(0, 1'b0); wait_cyc(3); drive(0, 1'b1);
      wait_busy_low(0, 10, ok);
      chk("glitch_busy_low_in_10", int'(ok), 1);
      wait_cyc(16);
      chk("glitch_no_pulse", dv_cnt[0] + fe_cnt[0], 0);
      send(0, 8'h5A, 1'b1);
      wait_cyc(8);
      chk("after_glitch_data", int'(if16.data_out), 8'h5A);

      // 0xA5 with exact latency from the first edge that samples the start bit
      d0 = dv_cnt[0];
      e1 = cyc + 1;
      send(0, 8'hA5, 1'b1);
      wait_cyc(4);
      chk("a5_pulse_count", dv_cnt[0] - d0, 1);
      chk("a5_latency", last_dv_cyc16 - e1, 2 + 7 + 144 + 1);
      chk("a5_data", int'(if16.data_out), 8'hA5);

      // 0x3C with low stop bit and held-low line
      d0 = dv_cnt[0]; f0 = fe_cnt[0];
      send(0, 8'h3C, 1'b0);
      wait_cyc(40);
      chk("ferr_pulse_count", fe_cnt[0] - f0, 1);
      chk("ferr_no_valid", dv_cnt[0] - d0, 0);
      chk("ferr_data_kept", int'(if16.data_out), 8'hA5);
      chk("ferr_busy_held", int'(if16.busy), 1);
      drive(0, 1'b1);
      wait_busy_low(0, 10, ok);
      chk("ferr_busy_release", int'(ok), 1);
      wait_cyc(16);
      send(0, 8'h81, 1'b1);
      wait_cyc(4);
      chk("after_ferr_data", int'(if16.data_out), 8'h81);

      // back-to-back at 2 clocks per bit
      act = 1;
      wait_cyc(4);
      d0 = dv_cnt[1];
      send(1, 8'h00, 1'b1);
      send(1, 8'hFF, 1'b1);
      send(1, 8'h55, 1'b1);
      wait_cyc(6);
      chk("b2b_pulse_count", dv_cnt[1] - d0, 3);
      chk("b2b_errors", fe_cnt[1], 0);
      chk("b2b_last_data", int'(if2.data_out), 8'h55);

      // reset during data bit 4
      act = 0;
      wait_cyc(4);
      d0 = dv_cnt[0] + fe_cnt[0];
      b = 8'hE7;
      drive(0, 1'b0); wait_cyc(16);
      for (int k = 0; k < 4; k++) begin drive(0, b[k]); wait_cyc(16); end
      drive(0, b[4]); wait_cyc(5);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", int'(if16.busy), 0);
      chk("abort_data", int'(if16.data_out), 0);
      wait_cyc(3);
      drive(0, 1'b1);
      wait_cyc(2);
      rst_n = 1'b1;
      wait_cyc(20);
      chk("abort_no_pulse", dv_cnt[0] + fe_cnt[0] - d0, 0);
      send(0, 8'hC3, 1'b1);
      wait_cyc(4);
      chk("after_abort_data", int'(if16.data_out), 8'hC3);

      // randomized traffic on both lines
      for (int n = 0; n < 40; n++) begin
         int s;
         s = int'($urandom_range(0, 1));
         if (s != act) begin wait_cyc(30); act = s; wait_cyc(2); end
         c = (s == 0) ? 16 : 2;
         kind = int'($urandom_range(0, 9));
         b = 8'($urandom_range(0, 255));
         if (kind == 0 && s == 0) begin
            len = int'($urandom_range(1, 5));
            drive(0, 1'b0); wait_cyc(len); drive(0, 1'b1); wait_cyc(16);
         end else if (kind == 1) begin
            send(s, b, 1'b0);
            wait_cyc(int'($urandom_range(0, 20)));
            drive(s, 1'b1);
            wait_cyc(2 * c);
         end else begin
            send(s, b, 1'b1);
            wait_cyc(c * int'($urandom_range(0, 2)));
         end
      end
      wait_cyc(40);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver: the downstream counterpart of the team's UART transmitter. It recovers 8N1 frames from an asynchronous serial line, using a 2-flop synchronizer and mid-bit sampling. Each received byte is presented with a one-cycle `data_valid` pulse; a bad stop bit raises `framing_error` instead. It sits between the chip's RX pad and the byte consumer (command decoder or RX FIFO).

## Interface
- `CLKS_PER_BIT`, default 2: clock cycles per bit (clock freq / baud). Must equal the transmitter's setting; legal range 2..255.
- `clk`  in  1  sole clock; all state on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low; one clock, reset asynchronous and active-low as decided.
- `rx_in`  in  1  raw serial line, idle high, asynchronous to `clk`.
- `data_out`  out  8  last correctly framed byte, LSB received first.
- `data_valid`  out  1  one-cycle pulse: `data_out` updated this cycle.
- `framing_error`  out  1  one-cycle pulse: stop bit sampled low; frame discarded.
- `busy`  out  1  high from start-bit detection until return to IDLE.

## Operation
- Synchronizer: `rx_in` passes through 2 flops, both reset to 1, giving `rx_s`. All FSM decisions use `rx_s` only.
- Define H = (CLKS_PER_BIT-1)/2 (integer division).
- Counter `cnt`: width 8, cleared on every state change.
- Bit index `idx`: 3 bits.
- Shift register `sh`: 8 bits, shifts right with the new bit entering at [7].
- FSM states:
  - IDLE: `busy`=0. If `rx_s`==0, go to START and set `busy`=1.
  - START: if `cnt`<H, increment `cnt`. At `cnt`==H (mid start bit): if `rx_s`==0, go to DATA with `idx`=0. Otherwise it was a glitch: go to IDLE with `busy`=0 and no pulse.
  - DATA: if `cnt`<CLKS_PER_BIT-1, increment `cnt`. Otherwise shift `rx_s` into `sh` and clear `cnt`. If `idx`==7, go to STOP; else increment `idx`.
  - STOP: wait CLKS_PER_BIT-1 cycles, then sample.
    - `rx_s`==1: `data_out`<=`sh`, pulse `data_valid`, go to IDLE, `busy`=0.
    - `rx_s`==0: pulse `framing_error`, leave `data_out` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: `busy` stays 1; wait for `rx_s`==1, then go to IDLE with `busy`=0. This stops a break or stuck-low line from being taken as repeated start bits.
  - Unused encodings go to IDLE.
- `data_valid` and `framing_error` are never high in the same cycle. Each is high for exactly one cycle per frame.
- No consumer backpressure: an unread byte is overwritten by the next valid frame.

## Timing
- Reset values: `data_out`=8'h00, `data_valid`=0, `framing_error`=0, `busy`=0, FSM=IDLE, synchronizer flops=1.
- Reset asserted mid-frame aborts immediately with no pulse. After release, reception restarts at the next falling edge seen in IDLE.
- Input latency: 2 cycles from `rx_in` to `rx_s`.
- Sampling points: start bit at H cycles after detection; data bit k at H + (k+1)·CLKS_PER_BIT; stop bit at H + 9·CLKS_PER_BIT.
- `data_valid` or `framing_error` is registered and high in the cycle after the stop-sample edge.
- Back-to-back frames: the stop sample falls mid stop bit, so IDLE is re-entered at least CLKS_PER_BIT-1-H cycles before the next start edge. Consecutive frames therefore need no idle gap. With CLKS_PER_BIT=2 (H=0) the margin is 1 cycle.

## Structure
- Package `uart_pkg`:
  - state enum (IDLE, START, DATA, STOP, WAIT_HIGH), shared with the transmitter's encoding style;
  - `UART_DATA_BITS`=8;
  - `UART_IDLE_LEVEL`=1'b1.
- Sub-module `uart_sync`: a parameterised 2-flop synchronizer with reset value 1. It is reused for other pad inputs.
- The FSM, counters and shift register live in `uart_rx`.

## Test plan
- Reset: hold `rst_n`=0 with `rx_in` toggling. All outputs stay at reset values and no pulses occur.
- CLKS_PER_BIT=16, frame 0xA5 with good stop bit: exactly one `data_valid` pulse 2+7+144+1 cycles after the start edge, `data_out`=8'hA5, no `framing_error`.
- CLKS_PER_BIT=16, `rx_in` low for 3 cycles then high: no pulses, `busy` returns to 0 within 10 cycles, and a following 0x5A frame is received correctly.
- CLKS_PER_BIT=16, frame 0x3C with stop bit low and line held low 40 cycles: one `framing_error` pulse, `data_out` stays 8'hA5, `busy`=1 until the line goes high, then the next frame 0x81 is received.
- Loopback from the team's UART transmitter, CLKS_PER_BIT=2, back-to-back bytes 0x00, 0xFF, 0x55: three `data_valid` pulses in order with matching `data_out`, no errors.
- Drop `rst_n` during data bit 4 of a frame: no pulse, `busy`=0 immediately. After release, a fresh 0xC3 frame is received correctly.
